sram_arbiter: RTL

- Shares the single external SRAM port (via the SRAM controller) between three requesters: the VGA fetch unit (port 0), the UART-to-SRAM writer (port 1) and the Milestone 1 datapath (port 2).
- Issues at most one SRAM access per clock.
- Tags each read and routes the returned data to its owner after a fixed latency.
- Prevents starvation of lower-priority ports with per-port wait counters.

---
 rtl/sram_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Three-port SRAM arbiter: fixed priority with wait-counter promotion, one
// access per clock, and tagged fixed-latency read return.
module sram_arbiter #(
  parameter int unsigned READ_LATENCY = 3,   // grant cycle to read_valid cycle, 2..7
  parameter int unsigned MAX_WAIT     = 15   // denied cycles before promotion, 1..255
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [2:0]  req,
  input  logic [2:0]  we_n,
  input  logic [53:0] address,
  input  logic [47:0] write_data,
  output logic [2:0]  grant,
  output logic [15:0] read_data,
  output logic [2:0]  read_valid,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  localparam int unsigned NUM_PORTS  = 3;
  // The read_valid/read_data register is the final stage of the latency.
  localparam int unsigned PIPE_DEPTH = READ_LATENCY - 1;
  localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);

  typedef struct packed {
    logic       valid;
    logic [1:0] port;
  } tag_t;

  logic [NUM_PORTS-1:0][7:0] wait_q, wait_d;
  tag_t [PIPE_DEPTH-1:0]     tag_q, tag_d;
  logic [17:0]               sram_address_q, sram_address_d;
  logic [15:0]               sram_write_data_q, sram_write_data_d;
  logic                      sram_we_n_q, sram_we_n_d;
  logic [15:0]               read_data_q, read_data_d;
  logic [2:0]                read_valid_q, read_valid_d;

  logic [2:0]  urgent;
  logic [2:0]  cand;
  logic [1:0]  gnt_idx;
  logic        gnt_any;
  logic [17:0] sel_address;
  logic [15:0] sel_write_data;
  logic        sel_we_n;
  tag_t        tag_in;
  tag_t        tag_out;

  // Urgent ports pre-empt the normal fixed-priority set entirely.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    urgent  = '0;
    grant   = '0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      urgent[i] = req[i] && (wait_q[i] == MAX_WAIT_C);
    end
    cand = (|urgent) ? urgent : req;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant      = '0;
        grant[i]   = 1'b1;
        gnt_idx    = 2'(i);
      end
    end
    gnt_any = |grant;
  end

  always_comb begin
    sel_address    = '0;
    sel_write_data = '0;
    sel_we_n       = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_address    = address[18*i +: 18];
        sel_write_data = write_data[16*i +: 16];
        sel_we_n       = we_n[i];
      end
    end
  end

  always_comb begin
    sram_address_d    = gnt_any ? sel_address    : sram_address_q;
    sram_write_data_d = gnt_any ? sel_write_data : sram_write_data_q;
    sram_we_n_d       = gnt_any ? sel_we_n       : 1'b1;

    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!req[i] || grant[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != MAX_WAIT_C) begin
        wait_d[i] = wait_q[i] + 8'd1;
      end else begin
        wait_d[i] = wait_q[i];
      end
    end

    // Writes and idle cycles push an invalid tag so read order stays aligned.
    tag_in.valid = gnt_any && sel_we_n;
    tag_in.port  = gnt_idx;
    tag_d[0]     = tag_in;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    tag_out = tag_q[PIPE_DEPTH-1];

    read_valid_d = tag_out.valid ? (3'b001 << tag_out.port) : 3'b000;
    read_data_d  = tag_out.valid ? SRAM_read_data : read_data_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      // NOTE: the tag pipeline is reset so in-flight reads are dropped, not returned after reset.
      tag_q             <= '0;
      wait_q            <= '0;
      sram_address_q    <= '0;
      sram_write_data_q <= '0;
      sram_we_n_q       <= 1'b1;
      read_data_q       <= '0;
      read_valid_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      tag_q             <= tag_d;
      wait_q            <= wait_d;
      sram_address_q    <= sram_address_d;
      sram_write_data_q <= sram_write_data_d;
      sram_we_n_q       <= sram_we_n_d;
      read_data_q       <= read_data_d;
      read_valid_q      <= read_valid_d;
    end
  end

  assign SRAM_address    = sram_address_q;
  assign SRAM_write_data = sram_write_data_q;
  assign SRAM_we_n       = sram_we_n_q;
  assign read_data       = read_data_q;
  assign read_valid      = read_valid_q;

endmodule
